// File: rtl/ssio_ddr_in_gearbox.sv
// ssio_ddr_in_gearbox: assembles per-edge DDR (or SDR) half-words into
// full 2*WIDTH words, realigning bursts that start on the falling edge.
//
// Ports:
//   clk, rst_n            capture clock, async active-low reset
//   in_q1/in_en1          rising-edge half-word and its valid
//   in_q2/in_en2          falling-edge half-word and its valid
//   sdr_mode              1 = SDR (q1 only), sampled in IDLE only
//   out_data/out_valid    assembled word (earlier half low), 1-cycle valid
//   out_shifted           word spans a cycle boundary (burst began on q2)
//   out_err/err_count     framing error pulse and saturating count
module ssio_ddr_in_gearbox #(
    parameter int WIDTH         = 4,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         in_q1,
    input  logic [WIDTH-1:0]         in_q2,
    input  logic                     in_en1,
    input  logic                     in_en2,
    input  logic                     sdr_mode,
    output logic [2*WIDTH-1:0]       out_data,
    output logic                     out_valid,
    output logic                     out_shifted,
    output logic                     out_err,
    output logic [ERR_CNT_WIDTH-1:0] err_count
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_DDR_RUN   = 2'd1;
    localparam logic [1:0] S_DDR_SHIFT = 2'd2;
    localparam logic [1:0] S_SDR_HALF  = 2'd3;

    logic [1:0]               state_q, state_d;
    logic [WIDTH-1:0]         hold_q, hold_d;
    logic [2*WIDTH-1:0]       data_q, data_d;
    logic                     valid_q, valid_d;
    logic                     shifted_q, shifted_d;
    logic                     err_q, err_d;
    logic [ERR_CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        shifted_d = 1'b0;
        err_d     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (sdr_mode) begin
                    // SDR: first q1 becomes the low half; en2 is ignored.
                    if (in_en1) begin
                        hold_d  = in_q1;
                        state_d = S_SDR_HALF;
                    end
                end else begin
                    unique case ({in_en1, in_en2})
                        2'b11: begin
                            data_d  = {in_q2, in_q1};
                            valid_d = 1'b1;
                            state_d = S_DDR_RUN;
                        end
                        2'b01: begin
                            hold_d  = in_q2;
                            state_d = S_DDR_SHIFT;
                        end
                        2'b10: err_d = 1'b1;
                        default: ;
                    endcase
                end
            end

            S_DDR_RUN: begin
                unique case ({in_en1, in_en2})
                    2'b11: begin
                        data_d  = {in_q2, in_q1};
                        valid_d = 1'b1;
                    end
                    2'b10: begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                    2'b01: begin
                        // Gap on q1: realign onto the falling edge.
                        err_d   = 1'b1;
                        hold_d  = in_q2;
                        state_d = S_DDR_SHIFT;
                    end
                    default: state_d = S_IDLE;
                endcase
            end

            S_DDR_SHIFT: begin
                unique case ({in_en1, in_en2})
                    2'b11: begin
                        data_d    = {in_q1, hold_q};
                        valid_d   = 1'b1;
                        shifted_d = 1'b1;
                        hold_d    = in_q2;
                    end
                    2'b10: begin
                        data_d    = {in_q1, hold_q};
                        valid_d   = 1'b1;
                        shifted_d = 1'b1;
                        state_d   = S_IDLE;
                    end
                    2'b01: begin
                        err_d  = 1'b1;
                        hold_d = in_q2;
                    end
                    default: begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                endcase
            end

            S_SDR_HALF: begin
                if (in_en1) begin
                    data_d  = {in_q1, hold_q};
                    valid_d = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (err_d && (cnt_q != {ERR_CNT_WIDTH{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            hold_q    <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            shifted_q <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            shifted_q <= shifted_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    assign out_data    = data_q;
    assign out_valid   = valid_q;
    assign out_shifted = shifted_q;
    assign out_err     = err_q;
    assign err_count   = cnt_q;

endmodule

// File: doc/ssio_ddr_in_gearbox.md
# ssio_ddr_in_gearbox

Edge-aligning gearbox behind the generic source-synchronous DDR input: consumes the per-edge half-words (q1 = rising-edge capture, q2 = falling-edge capture, q1 earlier in time) and per-edge enables in the capture clock domain, and assembles full 2×WIDTH words. It handles bursts starting on either edge, supports an SDR mode (q1 only, two cycles per word, e.g. RGMII 10/100), and flags runt, dangling and gapped bursts. It sits between the DDR input stage and the MAC receive logic.

## Interface
- WIDTH, 4: bits per edge half-word; output word is 2*WIDTH.
- ERR_CNT_WIDTH, 16: width of saturating error counter.

- clk  in  1  capture clock (the DDR input stage's output clock)
- rst_n  in  1  asynchronous, active-low reset
- in_q1  in  WIDTH  rising-edge half-word
- in_q2  in  WIDTH  falling-edge half-word
- in_en1  in  1  in_q1 valid
- in_en2  in  1  in_q2 valid
- sdr_mode  in  1  0 = DDR assembly, 1 = SDR (q1/en1 only); sampled only in IDLE
- out_data  out  2*WIDTH  assembled word, earlier half in low bits
- out_valid  out  1  out_data valid, single-cycle per word
- out_shifted  out  1  word was assembled across a cycle boundary (burst started on q2); qualified by out_valid
- out_err  out  1  one-cycle pulse on framing error
- err_count  out  ERR_CNT_WIDTH  saturating count of out_err pulses

## Operation
- States: IDLE, DDR_RUN, DDR_SHIFT, SDR_HALF. Internal hold register (WIDTH) stores a pending earlier half.
- IDLE, sdr_mode=0:
  - en1&en2: emit {q2,q1}; go DDR_RUN.
  - !en1&en2: hold<=q2; go DDR_SHIFT.
  - en1&!en2: runt; out_err; stay IDLE.
  - none: stay.
- IDLE, sdr_mode=1: en1 -> hold<=q1, go SDR_HALF; en2 ignored.
- DDR_RUN:
  - en1&en2: emit {q2,q1}.
  - none: clean end; go IDLE.
  - en1&!en2: truncated; out_err; go IDLE.
  - !en1&en2: gap; out_err; hold<=q2; go DDR_SHIFT.
- DDR_SHIFT:
  - en1&en2: emit {q1,hold}, out_shifted=1; hold<=q2.
  - en1&!en2: emit {q1,hold} shifted; clean end; go IDLE.
  - !en1&en2: gap; out_err; hold<=q2; stay.
  - none: dangling half; out_err; go IDLE.
- SDR_HALF:
  - en1: emit {q1,hold}, out_shifted=0; go IDLE.
  - !en1: dangling; out_err; go IDLE.
  - The next half is taken in IDLE the following cycle, so consecutive SDR words need no idle cycle.
- Error and emit in the same cycle are never both generated (transition table is exclusive).
- err_count increments on each out_err and saturates at all-ones.
- sdr_mode changes outside IDLE take effect at the next IDLE.

## Timing
- All outputs registered. out_valid/out_data/out_err are asserted the cycle after the input cycle that completes the word or detects the error.
- Latency: DDR_RUN 1 cycle from q2; DDR_SHIFT 1 cycle from the completing q1; SDR 1 cycle from the second q1.
- Throughput: one word per cycle in DDR, one per two cycles in SDR.
- Reset (async assert, sync-released use): state IDLE, hold=0, out_data=0, out_valid=0, out_shifted=0, out_err=0, err_count=0. Reset mid-burst discards hold, and no error is reported.
- out_data holds its last value when out_valid=0.

## Test plan
- DDR aligned, WIDTH=4:
  - Stimulus: 3 cycles en1=en2=1 with (q1,q2) = (1,2), (3,4), (5,6), then idle.
  - Required: out_data 0x21, 0x43, 0x65 on consecutive cycles; out_shifted=0; no out_err.
- DDR shifted:
  - Stimulus: cycle0 en2 only, q2=0xA; cycle1 both, q1=0xB, q2=0xC; cycle2 en1 only, q1=0xD.
  - Required: out_data 0xBA then 0xDC, out_shifted=1; returns to IDLE; no out_err.
- SDR:
  - Stimulus: sdr_mode=1; four cycles en1=1 with q1 = 5, 5, 0xD, 5 (en2 toggled randomly).
  - Required: out_data 0x55, 0x5D at cycles 2 and 4; q2 ignored.
- Errors:
  - Stimulus: runt (en1 only from IDLE), truncated DDR_RUN, dangling DDR_SHIFT.
  - Required: each gives exactly one out_err pulse with out_valid=0; err_count=3.
  - Separately, preload to saturation and confirm err_count holds at 0xFFFF.
- Reset mid-burst:
  - Stimulus: assert rst_n=0 while in DDR_SHIFT with hold=0x7.
  - Required: outputs zero immediately. After release, an aligned burst (1,2) yields 0x21 with no stale 0x7 and no out_err.
- Mode switch:
  - Stimulus: toggle sdr_mode mid-DDR burst.
  - Required: burst completes in DDR; the new mode applies from the next burst.
